// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state TAP FSM, instruction register
// (shift + update stages) and bypass register, feeding the 2:1 TDO mux.
module jtag_tap_ctrl #(
  parameter int unsigned         IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] BYPASS_OP  = 4'b1111,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instr,
  output logic                ir_so,
  output logic                bypass_so,
  output logic                sel,
  output logic                shift_dr,
  output logic                capture_dr,
  output logic                update_dr,
  output logic                shift_ir,
  output logic                bypass_en
);

  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] instr_q, instr_d;
  logic                byp_q, byp_d;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= TLR;
      ir_q    <= '0;
      instr_q <= IDCODE_OP;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      instr_q <= instr_d;
      byp_q   <= byp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:      state_d = TMS ? TLR      : RTI;
      RTI:      state_d = TMS ? SEL_DR   : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
      CAP_DR:   state_d = TMS ? EX1_DR   : SH_DR;
      SH_DR:    state_d = TMS ? EX1_DR   : SH_DR;
      EX1_DR:   state_d = TMS ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_d = TMS ? UPD_DR   : SH_DR;
      UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
      SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
      CAP_IR:   state_d = TMS ? EX1_IR   : SH_IR;
      SH_IR:    state_d = TMS ? EX1_IR   : SH_IR;
      EX1_IR:   state_d = TMS ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_d = TMS ? UPD_IR   : SH_IR;
      UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Register updates are keyed on the state before the edge, so the IR
  // shift stage, active instruction and bypass bit all lag the FSM by one.
  always_comb begin
    ir_d    = ir_q;
    instr_d = instr_q;
    byp_d   = byp_q;
    unique case (state_q)
      CAP_IR:  ir_d    = IR_CAPTURE;
      SH_IR:   ir_d    = {TDI, ir_q[IR_WIDTH-1:1]};
      UPD_IR:  instr_d = ir_q;
      TLR:     instr_d = IDCODE_OP;
      CAP_DR:  byp_d   = 1'b0;
      SH_DR:   byp_d   = TDI;
      default: ;
    endcase
  end

  always_comb begin
    sel        = 1'b0;
    shift_dr   = 1'b0;
    capture_dr = 1'b0;
    update_dr  = 1'b0;
    shift_ir   = 1'b0;
    unique case (state_q)
      CAP_DR:  capture_dr = 1'b1;
      SH_DR:   shift_dr   = 1'b1;
      UPD_DR:  update_dr  = 1'b1;
      SH_IR: begin
        sel      = 1'b1;
        shift_ir = 1'b1;
      end
      SEL_IR, CAP_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: sel = 1'b1;
      default: ;
    endcase
  end

  assign tap_state = state_q;
  assign instr     = instr_q;
  assign ir_so     = ir_q[0];
  assign bypass_so = byp_q;
  assign bypass_en = (instr_q == BYPASS_OP) || (instr_q == '1);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed self-checking bench for jtag_tap_ctrl: reset, FSM walk, TLR
// recovery, IR load, bypass path, Pause-IR hold and TRST mid-shift.
module tb_jtag_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b0;
  logic       TDI = 1'b0;
  logic [3:0] tap_state;
  logic [3:0] instr;
  logic       ir_so, bypass_so, sel;
  logic       shift_dr, capture_dr, update_dr, shift_ir, bypass_en;

  int unsigned tests = 0;
  int unsigned fails = 0;

  jtag_tap_ctrl #(
    .IR_WIDTH  (4),
    .IDCODE_OP (4'b0001),
    .BYPASS_OP (4'b1111),
    .IR_CAPTURE(4'b0101)
  ) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .TMS       (TMS),
    .TDI       (TDI),
    .tap_state (tap_state),
    .instr     (instr),
    .ir_so     (ir_so),
    .bypass_so (bypass_so),
    .sel       (sel),
    .shift_dr  (shift_dr),
    .capture_dr(capture_dr),
    .update_dr (update_dr),
    .shift_ir  (shift_ir),
    .bypass_en (bypass_en)
  );

  always #5 TCK = ~TCK;

  // One rising edge with the given TMS/TDI, outputs sampled 1 ns later.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic do_reset();
    TRST = 1'b1;
    step(1'b0, 1'b0);
    TRST = 1'b0;
  endtask

  task automatic test_reset();
    TRST = 1'b1;
    step(1'b0, 1'b1);  // TMS=0 must be overridden
    TRST = 1'b0;
    tests++; if (tap_state !== 4'hF) begin fails++; $display("FAIL reset_state got %h exp F", tap_state); end
    tests++; if (instr !== 4'b0001) begin fails++; $display("FAIL reset_instr got %b exp 0001", instr); end
    tests++; if ({sel, shift_dr, capture_dr, update_dr, shift_ir} !== 5'b0)
      begin fails++; $display("FAIL reset_decodes got %b exp 00000", {sel, shift_dr, capture_dr, update_dr, shift_ir}); end
    tests++; if ({ir_so, bypass_so, bypass_en} !== 3'b000)
      begin fails++; $display("FAIL reset_so got %b exp 000", {ir_so, bypass_so, bypass_en}); end
    step(1'b0, 1'b0);
    tests++; if (tap_state !== 4'hC) begin fails++; $display("FAIL reset_to_rti got %h exp C", tap_state); end
    tests++; if (instr !== 4'b0001) begin fails++; $display("FAIL rti_instr got %b exp 0001", instr); end
  endtask

  task automatic test_transitions();
    logic       tms_v [27] = '{0,1,0,0,1,0,1,0,1,1,1,1,0,1,0,1,0,1,1,1,0,1,1,0,1,1,0};
    logic [3:0] st_v  [27] = '{4'hC,4'h7,4'h6,4'h2,4'h1,4'h3,4'h0,4'h2,4'h1,4'h5,4'h7,4'h4,
                               4'hE,4'h9,4'hB,4'h8,4'hA,4'h9,4'hD,4'h7,4'h6,4'h1,4'h5,4'hC,
                               4'h7,4'h4,4'hE};
    logic       sel_v [27] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0,0,0,1,1};
    do_reset();
    for (int i = 0; i < 27; i++) begin
      step(tms_v[i], 1'b0);
      tests++; if (tap_state !== st_v[i]) begin fails++; $display("FAIL walk_state[%0d] got %h exp %h", i, tap_state, st_v[i]); end
      tests++; if (sel !== sel_v[i]) begin fails++; $display("FAIL walk_sel[%0d] got %b exp %b", i, sel, sel_v[i]); end
    end
    // Ex2DR with TMS=1 goes to UpdDR
    do_reset();
    step(0, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
    tests++; if (tap_state !== 4'h0) begin fails++; $display("FAIL walk_ex2dr got %h exp 0", tap_state); end
    step(1, 0);
    tests++; if (tap_state !== 4'h5) begin fails++; $display("FAIL walk_ex2dr_upd got %h exp 5", tap_state); end
    tests++; if (update_dr !== 1'b1) begin fails++; $display("FAIL update_dr got %b exp 1", update_dr); end
  endtask

  task automatic test_tlr_recovery();
    logic [3:0] exp_a [5] = '{4'h7, 4'h4, 4'hF, 4'hF, 4'hF};
    logic [3:0] exp_b [5] = '{4'h1, 4'h5, 4'h7, 4'h4, 4'hF};
    logic [3:0] exp_c [5] = '{4'h8, 4'hD, 4'h7, 4'h4, 4'hF};
    do_reset();
    step(0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      tests++; if (tap_state !== exp_a[i]) begin fails++; $display("FAIL tlr_from_rti[%0d] got %h exp %h", i, tap_state, exp_a[i]); end
    end
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);  // ShDR
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      tests++; if (tap_state !== exp_b[i]) begin fails++; $display("FAIL tlr_from_shdr[%0d] got %h exp %h", i, tap_state, exp_b[i]); end
    end
    step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(1, 0); step(0, 0);  // PauseIR
    tests++; if (tap_state !== 4'hB) begin fails++; $display("FAIL reach_pauseir got %h exp B", tap_state); end
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      tests++; if (tap_state !== exp_c[i]) begin fails++; $display("FAIL tlr_from_pauseir[%0d] got %h exp %h", i, tap_state, exp_c[i]); end
    end
  endtask

  task automatic test_load_instr();
    logic so_v  [4] = '{1, 0, 1, 0};
    logic [3:0] st_v [4] = '{4'hA, 4'hA, 4'hA, 4'h9};
    do_reset();
    step(0, 0);  // RTI
    step(1, 0); step(1, 0);
    tests++; if (sel !== 1'b1) begin fails++; $display("FAIL sel_selir got %b exp 1", sel); end
    step(0, 0);
    tests++; if (tap_state !== 4'hE || sel !== 1'b1)
      begin fails++; $display("FAIL capir got %h/%b exp E/1", tap_state, sel); end
    step(0, 0);
    tests++; if (shift_ir !== 1'b1 || shift_dr !== 1'b0)
      begin fails++; $display("FAIL shift_ir got %b/%b exp 1/0", shift_ir, shift_dr); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (ir_so !== so_v[i]) begin fails++; $display("FAIL ir_so[%0d] got %b exp %b", i, ir_so, so_v[i]); end
      step(i == 3, 1'b1);
      tests++; if (tap_state !== st_v[i] || sel !== 1'b1)
        begin fails++; $display("FAIL ir_shift_state[%0d] got %h/%b exp %h/1", i, tap_state, sel, st_v[i]); end
    end
    step(1, 0);
    tests++; if (tap_state !== 4'hD || instr !== 4'b0001)
      begin fails++; $display("FAIL updir got %h/%b exp D/0001", tap_state, instr); end
    step(0, 0);
    tests++; if (instr !== 4'b1111) begin fails++; $display("FAIL instr_loaded got %b exp 1111", instr); end
    tests++; if (bypass_en !== 1'b1 || sel !== 1'b0)
      begin fails++; $display("FAIL bypass_en got %b/%b exp 1/0", bypass_en, sel); end
  endtask

  task automatic test_bypass();
    logic tdi_v [4] = '{1, 0, 1, 1};
    step(1, 0);
    tests++; if (tap_state !== 4'h7 || shift_dr !== 1'b0)
      begin fails++; $display("FAIL seldr got %h/%b exp 7/0", tap_state, shift_dr); end
    step(0, 0);
    tests++; if (capture_dr !== 1'b1 || shift_dr !== 1'b0)
      begin fails++; $display("FAIL capture_dr got %b/%b exp 1/0", capture_dr, shift_dr); end
    step(0, 1);
    tests++; if (tap_state !== 4'h2 || shift_dr !== 1'b1 || bypass_so !== 1'b0)
      begin fails++; $display("FAIL shdr_entry got %h/%b/%b exp 2/1/0", tap_state, shift_dr, bypass_so); end
    for (int i = 0; i < 4; i++) begin
      step(i == 3, tdi_v[i]);
      tests++; if (bypass_so !== tdi_v[i]) begin fails++; $display("FAIL bypass_so[%0d] got %b exp %b", i, bypass_so, tdi_v[i]); end
    end
    tests++; if (tap_state !== 4'h1 || shift_dr !== 1'b0)
      begin fails++; $display("FAIL ex1dr got %h/%b exp 1/0", tap_state, shift_dr); end
    step(1, 0);
    tests++; if (update_dr !== 1'b1 || bypass_so !== 1'b1)
      begin fails++; $display("FAIL upddr got %b/%b exp 1/1", update_dr, bypass_so); end
    step(1, 0); step(0, 0); step(0, 1);  // SelDR, CapDR clears, ShDR
    tests++; if (bypass_so !== 1'b0) begin fails++; $display("FAIL capdr_clear got %b exp 0", bypass_so); end
    step(1, 0); step(1, 0); step(0, 0);  // back to RTI
    tests++; if (tap_state !== 4'hC) begin fails++; $display("FAIL bypass_rti got %h exp C", tap_state); end
  endtask

  task automatic test_pause_ir();
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);  // ShIR, IR=0101
    step(0, 0);                                      // IR=0010
    tests++; if (ir_so !== 1'b0) begin fails++; $display("FAIL pause_shift1 got %b exp 0", ir_so); end
    step(1, 1);                                      // IR=1001, Ex1IR
    step(0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      tests++; if (tap_state !== 4'hB || ir_so !== 1'b1 || instr !== 4'b1111)
        begin fails++; $display("FAIL pause_hold[%0d] got %h/%b/%b exp B/1/1111", i, tap_state, ir_so, instr); end
    end
    step(1, 0);
    step(0, 0);
    tests++; if (tap_state !== 4'hA || ir_so !== 1'b1)
      begin fails++; $display("FAIL pause_resume got %h/%b exp A/1", tap_state, ir_so); end
    step(0, 1);                                      // IR=1100
    step(1, 0);                                      // IR=0110, Ex1IR
    step(1, 0); step(0, 0);
    tests++; if (instr !== 4'b0110) begin fails++; $display("FAIL pause_instr got %b exp 0110", instr); end
    tests++; if (bypass_en !== 1'b0) begin fails++; $display("FAIL pause_bypass_en got %b exp 0", bypass_en); end
  endtask

  task automatic test_trst_mid_shift();
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);  // ShIR, IR=0101
    step(0, 1); step(0, 1);                          // IR=1101
    tests++; if (ir_so !== 1'b1 || tap_state !== 4'hA)
      begin fails++; $display("FAIL trst_pre got %b/%h exp 1/A", ir_so, tap_state); end
    TRST = 1'b1;
    step(0, 1);
    TRST = 1'b0;
    tests++; if (tap_state !== 4'hF || instr !== 4'b0001 || ir_so !== 1'b0)
      begin fails++; $display("FAIL trst_mid got %h/%b/%b exp F/0001/0", tap_state, instr, ir_so); end
    step(0, 0);
    tests++; if (instr !== 4'b0001 || tap_state !== 4'hC)
      begin fails++; $display("FAIL trst_after got %b/%h exp 0001/C", instr, tap_state); end
  endtask

  initial begin
    test_reset();
    test_transitions();
    test_tlr_recovery();
    test_load_instr();
    test_bypass();
    test_pause_ir();
    test_trst_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller for the ripple-adder JTAG chain. It sits directly upstream of the 2:1 TDO output mux. It runs the 16-state TAP FSM on TMS, holds the instruction register (IR) and the bypass register, and drives:
- the mux select (IR path vs DR path);
- the IR serial output (mux input b);
- the DR-side control strobes consumed by the boundary/scan data registers.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_OP, 4'b0001, instruction loaded on reset and in Test-Logic-Reset
BYPASS_OP, 4'b1111, bypass opcode; also selected when IR holds all ones
IR_CAPTURE, 4'b0101, value parallel-loaded into IR shift stage in Capture-IR (LSBs must be 2'b01)

Ports:
TCK  input  1  clock, all state updates on rising edge
TRST  input  1  synchronous active-high reset
TMS  input  1  test mode select, sampled each rising TCK
TDI  input  1  serial test data in
tap_state  output  4  current FSM state code
instr  output  IR_WIDTH  active instruction (update stage)
ir_so  output  1  IR shift stage bit 0, to TDO mux input b
bypass_so  output  1  bypass register output
sel  output  1  TDO mux select: 1 = IR path, 0 = DR path
shift_dr  output  1  high in Shift-DR
capture_dr  output  1  high in Capture-DR
update_dr  output  1  high in Update-DR
shift_ir  output  1  high in Shift-IR
bypass_en  output  1  high when instr == BYPASS_OP

Behaviour:
- One clock, TCK. TRST is synchronous and active-high, sampled on rising TCK, and overrides TMS.
- Reset values:
  - tap_state = TLR (4'hF)
  - instr = IDCODE_OP
  - IR shift stage = 0
  - bypass reg = 0
  - Decoded outputs follow from these: sel=0, all strobes 0, ir_so=0, bypass_so=0, bypass_en=0.
- State codes:
  - TLR F, RTI C
  - SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauseDR 3, Ex2DR 0, UpdDR 5
  - SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauseIR B, Ex2IR 8, UpdIR D
- Transitions, next state for TMS=0 / TMS=1:
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - IR column mirrors the DR column (CapIR..UpdIR).
- Five consecutive TMS=1 edges reach TLR from any state.
- All outputs except instr, ir_so and bypass_so are Moore decodes of the registered tap_state; they change in the same cycle as the state.
- sel = 1 in SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR; 0 elsewhere, including TLR and RTI.
- IR shift stage, on each rising TCK by the state before the edge:
  - CapIR: load IR_CAPTURE.
  - ShIR: {TDI, ir[IR_WIDTH-1:1]}, shifting LSB first.
  - Any other state: hold.
- instr, on each rising TCK:
  - UpdIR: load the shift stage.
  - TLR: load IDCODE_OP.
  - Any other state: hold.
  - An instruction therefore becomes active one edge after leaving Ex1IR/Ex2IR through UpdIR.
- Bypass register: CapDR loads 0; ShDR loads TDI; other states hold. This gives exactly one cycle of delay TDI -> bypass_so while shifting.
- bypass_en is combinational from instr.
- Pause states hold all registers indefinitely.
- TRST asserted mid-shift: the next edge forces all reset values; partially shifted IR bits are discarded and instr is not updated.

Test Plan:
- TRST=1 for one edge, then TMS=0 -> tap_state F then C; instr=4'b0001; sel=0; all strobes 0.
- From RTI (C), TMS=1,1,1,1,1 -> states 7,4,F,F,F; TMS=1 from any state (check ShDR and PauseIR) reaches F within 5 edges.
- Load instruction. From RTI apply TMS=1,1,0,0, then shift TDI=1,1,1,1 with TMS=0,0,0,1, then TMS=1,0:
  - In CapIR->ShIR, ir_so shifts out 1,0,1,0.
  - sel=1 throughout the IR column.
  - instr=4'b1111 after UpdIR; bypass_en=1.
- Bypass path with instr=BYPASS_OP:
  - CapDR, then ShDR with TDI pattern 1,0,1,1.
  - bypass_so = 0,1,0,1 on successive edges (one-cycle delay).
  - shift_dr=1 only in state 2.
- PauseIR hold:
  - Enter PauseIR after 2 shift bits and hold 10 cycles -> IR stage unchanged.
  - Resume via Ex2IR->ShIR and finish -> instr equals the concatenated 4-bit value.
- TRST asserted in ShIR after 2 bits -> next edge tap_state=F, instr=4'b0001, ir_so=0; instr never takes the partial value.
